// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the matrix memory controller: controller states,
// requester count and the memory depth helper.
// Pure declarations: no logic, no latency, no backpressure.
package mem_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,  // clear sweep in progress
    ST_RUN  = 1'b1   // arbitrating requests
  } state_t;

  localparam int NREQ = 2;

  // Number of words in an m x n matrix memory.
  function automatic int mem_depth(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: returns a one-hot grant from the valid bits.
// Latency: grant is combinational from valid; the pointer updates on the grant edge.
// Backpressure: a single valid is always granted; on a tie the requester not granted most recently wins.
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset (pointer favours requester 0)
//   valid     : per-requester valid bits
//   grant     : one-hot grant, zero when no requester is valid
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant
);

  // Index of the most recently granted requester. Resetting it to 1 makes
  // the first tie go to requester 0.
  logic last_q;

  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/matrix_mem_arbiter.sv
// Front-end for the single-port matrix memory: clears every word after reset, then shares it between two requesters.
// Latency: a request accepted at edge k gets its rsp_valid pulse (read data / write ack / range error) in cycle k+1.
// Backpressure: req_ready is low during the clear sweep; afterwards at most one requester is ready per cycle (round-robin).
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid / req_ready        : per-requester handshake (bit i = requester i)
//   req_we*, req_addr*, req_wdata*: per-requester command fields
//   rsp_valid, rsp_err, rsp_data : response pulse, out-of-range flag, read data (memory output passed through)
//   init_done                    : high once the clear sweep has finished
//   mem_*                        : memory controls, address, write data and registered read data
module matrix_mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DW = 8,
  parameter int m  = 8,
  parameter int n  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic                req_we0,
  input  logic                req_we1,
  input  logic [m+n-1:0]      req_addr0,
  input  logic [m+n-1:0]      req_addr1,
  input  logic [2*DW-1:0]     req_wdata0,
  input  logic [2*DW-1:0]     req_wdata1,
  output logic [NREQ-1:0]     rsp_valid,
  output logic                rsp_err,
  output logic [2*DW-1:0]     rsp_data,
  output logic                init_done,
  output logic                mem_ramEN,
  output logic                mem_writeEN,
  output logic                mem_readEN,
  output logic [m+n-1:0]      mem_addr,
  output logic [2*DW-1:0]     mem_data_in,
  input  logic [2*DW-1:0]     mem_data_out
);

  localparam int AW    = m + n;
  localparam int WW    = 2 * DW;
  localparam int DEPTH = mem_depth(m, n);

  // m*n < 2^(m+n) always holds, so both constants fit in AW bits.
  localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q;
  logic            run;
  logic [NREQ-1:0] arb_valid;
  logic [NREQ-1:0] grant;
  logic            sel;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [WW-1:0]   sel_wdata;
  logic            in_range;
  logic [NREQ-1:0] rsp_vld_q;
  logic            rsp_err_q;

  // Outputs are forced quiet while rst is high, even though the state
  // register only changes at the next edge.
  assign run       = (state_q == ST_RUN) && !rst;
  assign init_done = run;

  // Requests are invisible to the arbiter outside RUN, so the pointer
  // never moves during the sweep or reset.
  assign arb_valid = run ? req_valid : '0;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (arb_valid),
    .grant (grant)
  );

  assign req_ready = grant;

  assign sel       = grant[1];
  assign sel_we    = sel ? req_we1    : req_we0;
  assign sel_addr  = sel ? req_addr1  : req_addr0;
  assign sel_wdata = sel ? req_wdata1 : req_wdata0;
  assign in_range  = sel_addr < DEPTH_A;

  always_comb begin
    state_d     = state_q;
    mem_ramEN   = 1'b0;
    mem_writeEN = 1'b0;
    mem_readEN  = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          mem_ramEN   = 1'b1;
          mem_writeEN = 1'b1;
          mem_addr    = cnt_q;
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // Out-of-range requests are still accepted but never reach the memory.
          if ((|grant) && in_range) begin
            mem_ramEN   = 1'b1;
            mem_writeEN = sel_we;
            mem_readEN  = ~sel_we;
            mem_addr    = sel_addr;
            mem_data_in = sel_wdata;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      rsp_vld_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        cnt_q <= cnt_q + AW'(1);
      end
      rsp_vld_q <= grant;
      rsp_err_q <= (|grant) && !in_range;
    end
  end

  assign rsp_valid = rsp_vld_q & {NREQ{~rst}};
  assign rsp_err   = rsp_err_q & ~rst;

  // The memory registers its read internally, so the word it presents in
  // the response cycle already belongs to the accepted read.
  assign rsp_data = mem_data_out;

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
module tb_matrix_mem_arbiter;

  localparam int AW    = 16;
  localparam int WW    = 16;
  localparam int DEPTH = 64;

  logic          clk;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic          req_we0, req_we1;
  logic [AW-1:0] req_addr0, req_addr1;
  logic [WW-1:0] req_wdata0, req_wdata1;
  logic [1:0]    rsp_valid;
  logic          rsp_err;
  logic [WW-1:0] rsp_data;
  logic          init_done;
  logic          mem_ramEN, mem_writeEN, mem_readEN;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_data_in;
  logic [WW-1:0] mem_data_out;

  int n_checks = 0;
  int n_pass   = 0;

  matrix_mem_arbiter #(.DW(8), .m(8), .n(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we0      (req_we0),
    .req_we1      (req_we1),
    .req_addr0    (req_addr0),
    .req_addr1    (req_addr1),
    .req_wdata0   (req_wdata0),
    .req_wdata1   (req_wdata1),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_data     (rsp_data),
    .init_done    (init_done),
    .mem_ramEN    (mem_ramEN),
    .mem_writeEN  (mem_writeEN),
    .mem_readEN   (mem_readEN),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with one-cycle registered read.
  logic [WW-1:0] mem_arr [DEPTH];
  always @(posedge clk) begin
    if (mem_ramEN) begin
      if (mem_writeEN) mem_arr[mem_addr[5:0]] <= mem_data_in;
      else if (mem_readEN) mem_data_out <= mem_arr[mem_addr[5:0]];
    end
  end

  // ---------------- reference model ----------------
  logic [WW-1:0] ref_mem [DEPTH];
  int            last_g;       // requester granted most recently
  bit            pend_vld;
  int            pend_idx;
  bit            pend_err;
  bit            pend_rd;
  logic [WW-1:0] pend_data;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_g   = 1;
    pend_vld = 0;
  endtask

  function automatic logic [1:0] exp_grant(input logic [1:0] v);
    if (v == 2'b11) return (last_g == 0) ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Applies the request the DUT should accept at the coming edge.
  task automatic model_accept();
    logic [1:0]    g;
    logic [AW-1:0] a;
    logic          w;
    logic [WW-1:0] d;
    g        = exp_grant(req_valid);
    pend_vld = (g != 2'b00);
    if (pend_vld) begin
      pend_idx = g[1] ? 1 : 0;
      a        = g[1] ? req_addr1  : req_addr0;
      w        = g[1] ? req_we1    : req_we0;
      d        = g[1] ? req_wdata1 : req_wdata0;
      pend_err = (a >= DEPTH);
      pend_rd  = !w;
      if (!pend_err) begin
        if (w) ref_mem[a[5:0]] = d;
        else   pend_data = ref_mem[a[5:0]];
      end
      last_g = pend_idx;
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic w0, input logic [AW-1:0] a0,
                       input logic [WW-1:0] d0, input logic w1, input logic [AW-1:0] a1,
                       input logic [WW-1:0] d1);
    req_valid = v;
    req_we0 = w0; req_addr0 = a0; req_wdata0 = d0;
    req_we1 = w1; req_addr1 = a1; req_wdata1 = d1;
  endtask

  // Call right after rst has been released (one time unit after an edge).
  // Holds both requesters valid and measures the sweep.
  task automatic sweep_measure(output int cyc, output int rdy_seen, output int bad,
                               output int rsp_seen, output logic [1:0] rdy_at_done);
    cyc = -1; rdy_seen = 0; bad = 0; rsp_seen = 0; rdy_at_done = 2'bxx;
    drive(2'b11, 1'b0, 16'd3, 16'h0, 1'b1, 16'd7, 16'hFFFF);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) begin
        cyc = i;
        rdy_at_done = req_ready;
        break;
      end
      if (req_ready !== 2'b00) rdy_seen++;
      if (rsp_valid !== 2'b00) rsp_seen++;
      if (mem_ramEN !== 1'b1 || mem_writeEN !== 1'b1 || mem_readEN !== 1'b0 ||
          mem_addr !== 16'(i) || mem_data_in !== 16'h0) bad++;
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc, rs, bad, rsps;
    logic [1:0] rd;
    rst = 1'b1;
    drive(2'b11, 1'b0, 16'd1, 16'h0, 1'b0, 16'd2, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready got %b exp 00", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b exp 0", rsp_err); else n_pass++;
    n_checks++; if (init_done !== 1'b0) $display("FAIL reset_init_done got %b exp 0", init_done); else n_pass++;
    n_checks++; if ({mem_ramEN, mem_writeEN, mem_readEN} !== 3'b000)
      $display("FAIL reset_mem_en got %b exp 000", {mem_ramEN, mem_writeEN, mem_readEN}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_measure(cyc, rs, bad, rsps, rd);
    n_checks++; if (cyc !== 64) $display("FAIL sweep_len got %0d exp 64", cyc); else n_pass++;
    n_checks++; if (rs !== 0) $display("FAIL sweep_ready got %0d ready cycles exp 0", rs); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL sweep_writes got %0d bad cycles exp 0", bad); else n_pass++;
    n_checks++; if (rd !== 2'b01) $display("FAIL first_ready got %b exp 01", rd); else n_pass++;
    model_reset();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g, prev_g;
    prev_g = 2'b00;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (k < 6) drive(2'b11, 1'b0, 16'(k), 16'h0, 1'b0, 16'(k + 8), 16'h0);
      else req_valid = 2'b00;
      @(negedge clk);
      exp_g = (k < 6) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      n_checks++; if (req_ready !== exp_g) $display("FAIL contention_grant[%0d] got %b exp %b", k, req_ready, exp_g); else n_pass++;
      n_checks++; if (rsp_valid !== prev_g) $display("FAIL contention_rsp[%0d] got %b exp %b", k, rsp_valid, prev_g); else n_pass++;
      if (prev_g != 2'b00) begin
        n_checks++; if (rsp_data !== 16'h0) $display("FAIL contention_data[%0d] got %h exp 0000", k, rsp_data); else n_pass++;
      end
      model_accept();
      prev_g = exp_g;
    end
  endtask

  task automatic test_sweep_reads();
    logic [AW-1:0] addrs [3];
    addrs[0] = 16'd0; addrs[1] = 16'd31; addrs[2] = 16'd63;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) drive(2'b01, 1'b0, addrs[k], 16'h0, 1'b0, 16'h0, 16'h0);
      else req_valid = 2'b00;
      @(negedge clk);
      if (k > 0) begin
        n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h0)
          $display("FAIL sweep_read[%0d] got valid %b data %h exp 01 0000", addrs[k-1], rsp_valid, rsp_data); else n_pass++;
      end
      model_accept();
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    drive(2'b01, 1'b1, 16'd5, 16'hA5A5, 1'b0, 16'd0, 16'h0);
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b01) $display("FAIL single_wr_ready got %b exp 01", req_ready); else n_pass++;
    n_checks++; if ({mem_ramEN, mem_writeEN, mem_readEN} !== 3'b110 || mem_addr !== 16'd5 || mem_data_in !== 16'hA5A5)
      $display("FAIL single_wr_mem got en %b addr %h data %h exp 110 0005 a5a5",
               {mem_ramEN, mem_writeEN, mem_readEN}, mem_addr, mem_data_in); else n_pass++;
    model_accept();
    @(posedge clk); #1;
    drive(2'b01, 1'b0, 16'd5, 16'h0, 1'b0, 16'd0, 16'h0);
    @(negedge clk);
    n_checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) $display("FAIL single_wr_ack got %b err %b exp 01 0", rsp_valid, rsp_err); else n_pass++;
    n_checks++; if ({mem_ramEN, mem_writeEN, mem_readEN} !== 3'b101) $display("FAIL single_rd_en got %b exp 101", {mem_ramEN, mem_writeEN, mem_readEN}); else n_pass++;
    model_accept();
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 16'hA5A5) $display("FAIL single_raw got %b %h exp 01 a5a5", rsp_valid, rsp_data); else n_pass++;
    n_checks++; if (mem_ramEN !== 1'b0 || mem_addr !== 16'h0 || mem_data_in !== 16'h0)
      $display("FAIL idle_mem got en %b addr %h data %h exp 0 0000 0000", mem_ramEN, mem_addr, mem_data_in); else n_pass++;
    model_accept();
  endtask

  task automatic test_out_of_range();
    @(posedge clk); #1;
    drive(2'b10, 1'b0, 16'd0, 16'h0, 1'b1, 16'd64, 16'h1234);
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b10 || mem_ramEN !== 1'b0) $display("FAIL oor_accept got ready %b ramEN %b exp 10 0", req_ready, mem_ramEN); else n_pass++;
    model_accept();
    @(posedge clk); #1;
    drive(2'b01, 1'b0, 16'd0, 16'h0, 1'b0, 16'd0, 16'h0);
    @(negedge clk);
    n_checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1) $display("FAIL oor_rsp got %b err %b exp 10 1", rsp_valid, rsp_err); else n_pass++;
    model_accept();
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_data !== 16'h0)
      $display("FAIL oor_followup got %b err %b data %h exp 01 0 0000", rsp_valid, rsp_err, rsp_data); else n_pass++;
    model_accept();
  endtask

  task automatic test_random();
    logic [1:0] g, exp_rv;
    logic [AW-1:0] a;
    logic w;
    int errs;
    errs = 0;
    for (int c = 0; c <= 400; c++) begin
      @(posedge clk); #1;
      if (c < 400) begin
        req_valid  = 2'($urandom_range(0, 3));
        req_we0    = 1'($urandom_range(0, 1));
        req_we1    = 1'($urandom_range(0, 1));
        req_addr0  = ($urandom_range(0, 9) == 0) ? 16'(64 + $urandom_range(0, 65000)) : 16'($urandom_range(0, 15));
        req_addr1  = ($urandom_range(0, 9) == 0) ? 16'(64 + $urandom_range(0, 65000)) : 16'($urandom_range(0, 15));
        req_wdata0 = 16'($urandom);
        req_wdata1 = 16'($urandom);
      end else begin
        req_valid = 2'b00;
      end
      @(negedge clk);
      exp_rv = pend_vld ? (pend_idx == 1 ? 2'b10 : 2'b01) : 2'b00;
      n_checks++; if (rsp_valid !== exp_rv) begin errs++; $display("FAIL rand_rsp_valid[%0d] got %b exp %b", c, rsp_valid, exp_rv); end else n_pass++;
      if (pend_vld) begin
        n_checks++; if (rsp_err !== pend_err) begin errs++; $display("FAIL rand_rsp_err[%0d] got %b exp %b", c, rsp_err, pend_err); end else n_pass++;
        if (pend_rd && !pend_err) begin
          n_checks++; if (rsp_data !== pend_data) begin errs++; $display("FAIL rand_rsp_data[%0d] got %h exp %h", c, rsp_data, pend_data); end else n_pass++;
        end
      end
      g = exp_grant(req_valid);
      n_checks++; if (req_ready !== g) begin errs++; $display("FAIL rand_grant[%0d] got %b exp %b", c, req_ready, g); end else n_pass++;
      a = g[1] ? req_addr1 : req_addr0;
      w = g[1] ? req_we1 : req_we0;
      if (g != 2'b00 && a < DEPTH) begin
        n_checks++; if (mem_ramEN !== 1'b1 || mem_writeEN !== w || mem_readEN !== !w || mem_addr !== a)
          begin errs++; $display("FAIL rand_mem[%0d] got en %b%b%b addr %h exp 1%b%b %h", c, mem_ramEN, mem_writeEN, mem_readEN, mem_addr, w, !w, a); end else n_pass++;
      end else begin
        n_checks++; if (mem_ramEN !== 1'b0) begin errs++; $display("FAIL rand_mem_idle[%0d] got ramEN %b exp 0", c, mem_ramEN); end else n_pass++;
      end
      model_accept();
      if (errs > 20) break;
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc, rs, bad, rsps;
    logic [1:0] rd;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_ramEN !== 1'b0 || init_done !== 1'b0) $display("FAIL midsweep_rst_quiet got ramEN %b done %b exp 0 0", mem_ramEN, init_done); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_measure(cyc, rs, bad, rsps, rd);
    n_checks++; if (cyc !== 64) $display("FAIL midsweep_len got %0d exp 64", cyc); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL midsweep_restart got %0d bad cycles exp 0", bad); else n_pass++;
    model_reset();
  endtask

  task automatic test_reset_in_run();
    int cyc, rs, bad, rsps;
    logic [1:0] rd;
    // Leave a non-zero word so the repeated sweep is visible.
    @(posedge clk); #1;
    drive(2'b10, 1'b0, 16'd0, 16'h0, 1'b1, 16'd9, 16'hBEEF);
    @(negedge clk); model_accept();
    @(posedge clk); #1;
    drive(2'b01, 1'b0, 16'd9, 16'h0, 1'b0, 16'd0, 16'h0);
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b01) $display("FAIL run_rst_accept got %b exp 01", req_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 2'b00) $display("FAIL run_rst_drop got %b exp 00", rsp_valid); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_measure(cyc, rs, bad, rsps, rd);
    n_checks++; if (rsps !== 0) $display("FAIL run_rst_late_rsp got %0d pulses exp 0", rsps); else n_pass++;
    n_checks++; if (cyc !== 64) $display("FAIL run_rst_sweep_len got %0d exp 64", cyc); else n_pass++;
    model_reset();
    @(posedge clk); #1;
    drive(2'b01, 1'b0, 16'd9, 16'h0, 1'b0, 16'd0, 16'h0);
    @(negedge clk); model_accept();
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h0) $display("FAIL run_rst_cleared got %b %h exp 01 0000", rsp_valid, rsp_data); else n_pass++;
    model_accept();
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    model_reset();
    test_reset();
    test_contention();
    test_sweep_reads();
    test_single();
    test_out_of_range();
    test_random();
    test_reset_mid_sweep();
    test_reset_in_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/matrix_mem_arbiter.md
# matrix_mem_arbiter

Controller that sits in front of the single-port matrix memory (depth m*n, word width 2*DW, one-cycle registered read) and shares it between two requesters. After reset it runs a clear sweep that writes zero to every location, then arbitrates requests round-robin with a valid/ready handshake. It returns read data and write acknowledges one cycle after acceptance and flags out-of-range addresses.

## Interface
Parameters:
- DW, 8, half word width; the memory word is 2*DW bits.
- m, 8, matrix rows.
- n, 8, matrix columns; depth is m*n and the address width is m+n.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; a request is accepted when valid&ready is high at the posedge.
- req_we0 / req_we1  in  1  1 = write, 0 = read.
- req_addr0 / req_addr1  in  m+n  word address.
- req_wdata0 / req_wdata1  in  2*DW  write data.
- rsp_valid  out  2  one-cycle pulse to the requester whose request was accepted on the previous cycle.
- rsp_err  out  1  valid with rsp_valid; 1 = the address was out of range.
- rsp_data  out  2*DW  read data, shared by both requesters; meaningful only with rsp_valid, an in-range read, and rsp_err=0.
- init_done  out  1  high once the clear sweep has finished.
- mem_ramEN, mem_writeEN, mem_readEN  out  1  memory controls.
- mem_addr  out  m+n  memory address.
- mem_data_in  out  2*DW  memory write data.
- mem_data_out  in  2*DW  memory read data (registered inside the memory).

## Operation
- State machine with two states, INIT and RUN.
  - Reset places the block in INIT with the sweep counter at 0.
- INIT:
  - Each cycle drives mem_ramEN=1, mem_writeEN=1, mem_readEN=0, mem_addr=counter, mem_data_in=0.
  - The counter increments each cycle. After writing address m*n-1, the block moves to RUN on the next edge.
  - req_ready=0 throughout INIT.
- RUN:
  - Grant rule: if exactly one req_valid bit is high, that requester is granted. If both are high, the requester not granted most recently wins.
  - The last-grant pointer updates only on a grant. After reset it favours requester 0.
  - req_ready is combinational and equals the one-hot grant. Only one requester is ready per cycle, and none when neither is valid.
- Granted in-range request (addr < m*n):
  - mem_ramEN=1, mem_writeEN=req_we, mem_readEN=~req_we.
  - mem_addr and mem_data_in come from the winning requester.
- Granted out-of-range request (addr >= m*n):
  - Accepted, but the memory is not touched: mem_ramEN=0.
  - Next cycle: rsp_valid[i]=1 and rsp_err=1.
- Response: every accepted request produces exactly one rsp_valid pulse, one cycle later. Writes receive a pulse too, as an acknowledge.
- rsp_data is mem_data_out passed straight through.
- No grant: all memory enables are 0, and mem_addr and mem_data_in hold 0.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, init_done=0, and all mem_* enables 0 while rst is high.
- Clear sweep takes exactly m*n cycles after rst deasserts (64 at defaults).
  - init_done and the first req_ready appear in cycle m*n, counting the first post-reset cycle as cycle 0.
- Throughput: one accepted request per cycle. Back-to-back requests from both requesters alternate grants 0,1,0,1.
- Latency: accept at edge k gives rsp_valid high during cycle k+1 for exactly one cycle.
- Read-after-write to the same address, accepted on consecutive cycles, returns the new data.
- rst asserted mid-INIT restarts the sweep at 0.
- rst asserted in RUN drops any pending response (rsp_valid=0 in the next cycle) and re-enters INIT.
- A requester may change req_addr, req_we or req_wdata freely while not accepted. There is no hold requirement and no minimum valid duration.

## Structure
- Shared package mem_ctrl_pkg holds:
  - the state encoding (ST_INIT, ST_RUN);
  - NREQ=2;
  - a depth function or constant m*n.
- Natural sub-module: rr_arbiter2. It takes the valid bits and returns the one-hot grant, and owns the last-grant pointer with a synchronous reset to "favour 0".
- Range check, mux, sweep counter and response register live in the top block.

## Test plan
- Sweep: release reset, then read addresses 0, 31 and 63 after init_done. Expect rsp_data=0 for all three, init_done rising exactly 64 cycles after reset release, and req_ready=0 before that.
- Single requester: req 0 writes 16'hA5A5 to addr 5, then reads addr 5. Expect rsp_valid[0] on both following cycles and rsp_data=16'hA5A5 on the read response.
- Contention: both requesters hold valid reads for 6 cycles. Expect grants 0,1,0,1,0,1 and rsp_valid alternating one cycle behind.
- Out of range: req 1 writes 16'h1234 to addr 64. Expect rsp_valid[1]=1, rsp_err=1 and mem_ramEN=0 that cycle; a later in-range read of addr 0 returns 0.
- Reset mid-sweep: assert rst at sweep cycle 30 for one cycle. Expect init_done only 64 cycles after the second release.
- Reset in RUN: assert rst in the cycle after an accepted read. Expect no rsp_valid, the block back in INIT, and a full sweep again.
